// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder
//   Multi-cycle adder that processes CHUNK bits of the operands per clock.
//   A start accepted in IDLE captures the operands and carry-in. The block
//   then spends NCHUNK clocks in RUN, one chunk per clock, starting at the
//   least significant chunk. When the last chunk completes, sum/cout load
//   the full result and done pulses for one cycle. sum/cout keep the last
//   completed result, so partial sums are never visible on them.
//
// Parameters
//   WIDTH  operand/sum width (4..64)
//   CHUNK  bits added per clock; WIDTH must be a multiple of CHUNK
//
// Ports
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   start  begin an addition (sampled only in IDLE)
//   a, b   operands, captured on accepted start
//   cin    carry-in, captured on accepted start
//   sub    (SERIAL_ADDER_SUB_EN only) 1 = compute a - b as a + ~b + 1
//   busy   high while in RUN
//   done   one-cycle completion pulse
//   sum    result of the last completed operation
//   cout   carry-out of the last completed operation (for sub: 1 = no borrow)
//
// Build option
//   SERIAL_ADDER_SUB_EN  adds the sub input and subtract mode
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] psum, psum_next;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             last;
  logic [CHUNK:0]   csum;

  // Chunk adder for the current index, and the partial sum with that
  // chunk written in place.
  always_comb begin
    csum      = {1'b0, a_r[idx*CHUNK +: CHUNK]}
              + {1'b0, b_r[idx*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
    psum_next = psum;
    psum_next[idx*CHUNK +: CHUNK] = csum[CHUNK-1:0];
    last      = (idx == IW'(NCHUNK - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      psum  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r  <= a;
            psum <= '0;
            idx  <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            // Subtraction reuses the adder: invert b and force carry-in to 1.
            b_r   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
`else
            b_r   <= b;
            carry <= cin;
`endif
          end
        end
        RUN: begin
          psum  <= psum_next;
          carry <= csum[CHUNK];
          if (last) begin
            sum  <= psum_next;
            cout <= csum[CHUNK];
            done <= 1'b1;
            idx  <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_chunk_adder.sv
module tb_serial_chunk_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic         s_start = 1'b0;
  logic [W-1:0] s_a = '0;
  logic [W-1:0] s_b = '0;
  logic         s_cin = 1'b0;
  logic         s_busy, s_done, s_cout;
  logic [W-1:0] s_sum;

`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
  logic         s_sub = 1'b0;
`endif

  int n_checks = 0;
  int n_pass = 0;
  int done_count = 0;
  logic [W:0] sbq[$];
  logic [W:0] exp_v;

  always #5 clk = ~clk;

  serial_chunk_adder #(.WIDTH(W), .CHUNK(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_chunk_adder #(.WIDTH(W), .CHUNK(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(s_sub),
`endif
    .busy(s_busy), .done(s_done), .sum(s_sum), .cout(s_cout)
  );

  function automatic logic [W:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                       input logic icin, input logic isub);
    if (isub) return {1'b0, ia} + {1'b0, ~ib} + {{W{1'b0}}, 1'b1};
    return {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, icin};
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      done_count++;
      n_checks++;
      if (sbq.size() == 0) begin
        $display("FAIL sb_unexpected_done got sum=%h cout=%b required no done", sum, cout);
      end else begin
        exp_v = sbq.pop_front();
        if ({cout, sum} !== exp_v)
          $display("FAIL sb_result got cout=%b sum=%h required cout=%b sum=%h",
                   cout, sum, exp_v[W], exp_v[W-1:0]);
        else
          n_pass++;
      end
    end
  end

  // Drive a start for one edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic icin, input logic isub, input bit push);
    a = ia; b = ib; cin = icin;
`ifdef SERIAL_ADDER_SUB_EN
    sub = isub;
`endif
    start = 1'b1;
    if (push) sbq.push_back(model(ia, ib, icin, isub));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    #12;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b required 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b required 0", done); else n_pass++;
    n_checks++; if (sum !== '0) $display("FAIL reset_sum got %h required 0000", sum); else n_pass++;
    n_checks++; if (cout !== 1'b0) $display("FAIL reset_cout got %b required 0", cout); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int cyc, busy_cyc;
    start_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b1);
    cyc = 0; busy_cyc = 0;
    if (busy) busy_cyc++;
    while (!done && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) busy_cyc++;
    end
    n_checks++; if (cyc != 4) $display("FAIL basic_latency got %0d required 4", cyc); else n_pass++;
    n_checks++; if (busy_cyc != 4) $display("FAIL basic_busy_cycles got %0d required 4", busy_cyc); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) $display("FAIL basic_done_width got %b required 0", done); else n_pass++;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if ({cout, sum} !== {1'b0, 16'h2201})
      $display("FAIL basic_hold got cout=%b sum=%h required cout=0 sum=2201", cout, sum);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int cyc;
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    wait_done(cyc);
    n_checks++; if (cyc != 4) $display("FAIL b2b_latency1 got %0d required 4", cyc); else n_pass++;
    start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    n_checks++; if (busy !== 1'b1) $display("FAIL b2b_no_gap got busy=%b required 1", busy); else n_pass++;
    wait_done(cyc);
    n_checks++; if (cyc != 4) $display("FAIL b2b_latency2 got %0d required 4", cyc); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start;
    int d0;
    start_op(16'h1111, 16'h2222, 1'b1, 1'b0, 1'b1);
    d0 = done_count;
    for (int i = 0; i < 4; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      start = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_checks++; if (done !== 1'b1) $display("FAIL ignore_latency got done=%b required 1", done); else n_pass++;
    repeat (8) @(posedge clk); #1;
    n_checks++;
    if (done_count - d0 != 1) $display("FAIL ignore_single_done got %0d required 1", done_count - d0);
    else n_pass++;
  endtask

  task automatic test_abort;
    int cyc, d0;
    start_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    d0 = done_count;
    rst_n = 1'b0; #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b required 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL abort_done got %b required 0", done); else n_pass++;
    n_checks++; if (sum !== '0) $display("FAIL abort_sum got %h required 0000", sum); else n_pass++;
    n_checks++; if (cout !== 1'b0) $display("FAIL abort_cout got %b required 0", cout); else n_pass++;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    start_op(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
    n_checks++; if (busy !== 1'b1) $display("FAIL abort_restart got busy=%b required 1", busy); else n_pass++;
    wait_done(cyc);
    n_checks++; if (cyc != 4) $display("FAIL abort_latency got %0d required 4", cyc); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (done_count - d0 != 1) $display("FAIL abort_done_count got %0d required 1", done_count - d0);
    else n_pass++;
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    int cyc;
    start_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    wait_done(cyc);
    n_checks++; if (cyc != 4) $display("FAIL sub_latency1 got %0d required 4", cyc); else n_pass++;
    start_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1);
    wait_done(cyc);
    n_checks++; if (cyc != 4) $display("FAIL sub_latency2 got %0d required 4", cyc); else n_pass++;
    @(posedge clk); #1;
    sub = 1'b0;
  endtask
`endif

  task automatic test_random_stream;
    int cyc;
    logic s;
    s = 1'b0;
    start_op(W'($urandom), W'($urandom), 1'($urandom), s, 1'b1);
    for (int i = 0; i < 8; i++) begin
      wait_done(cyc);
      n_checks++; if (cyc != 4) $display("FAIL rand_latency got %0d required 4", cyc); else n_pass++;
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom);
`endif
      if (i < 7) start_op(W'($urandom), W'($urandom), 1'($urandom), s, 1'b1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_chunk;
    @(negedge clk);
    s_a = 16'h8000; s_b = 16'h8000; s_cin = 1'b0; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    n_checks++; if (s_busy !== 1'b1) $display("FAIL chunk1_busy got %b required 1", s_busy); else n_pass++;
    n_checks++; if (s_done !== 1'b0) $display("FAIL chunk1_early_done got %b required 0", s_done); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (s_done !== 1'b1) $display("FAIL chunk1_done got %b required 1", s_done); else n_pass++;
    n_checks++;
    if ({s_cout, s_sum} !== {1'b1, 16'h0000})
      $display("FAIL chunk1_result got cout=%b sum=%h required cout=1 sum=0000", s_cout, s_sum);
    else n_pass++;
    n_checks++; if (s_busy !== 1'b0) $display("FAIL chunk1_idle got busy=%b required 0", s_busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_abort();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_random_stream();
    test_single_chunk();
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (sbq.size() != 0) $display("FAIL sb_leftover got %0d required 0", sbq.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
